// File: rtl/cp0_intc.sv
// CP0 coprocessor with integrated interrupt controller for the MonkeyMIPS core.
// Holds Count/Compare/Status/Cause/EPC, synchronises int_i and raises int_req_o.
module cp0_intc #(
    parameter int NUM_INT     = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_EN    = 1,
    parameter int COUNT_DIV   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_i,
    input  logic [4:0]         raddr_i,
    output logic [31:0]        data_o,
    input  logic               we_i,
    input  logic [4:0]         waddr_i,
    input  logic [31:0]        wdata_i,
    input  logic               exc_valid_i,
    input  logic [4:0]         execode_i,
    input  logic [31:0]        exc_pc_i,
    input  logic               exc_bd_i,
    input  logic               eret_i,
    output logic               int_req_o,
    output logic               timer_int_o,
    output logic [31:0]        status_o,
    output logic [31:0]        cause_o,
    output logic [31:0]        epc_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
    logic [5:0]         ext_ip;
    logic [7:2]         ip_hw_q;
    logic [3:0]         presc_q;
    logic [31:0]        count_q;
    logic [31:0]        compare_q;
    logic               timer_q;
    logic [7:0]         im_q;
    logic               exl_q;
    logic               ie_q;
    logic               bd_q;
    logic [4:0]         exc_code_q;
    logic [1:0]         ip_sw_q;
    logic [31:0]        epc_q;
    logic [7:0]         ip;
    logic               tick;
    logic               count_wr;
    logic               compare_wr;

    assign count_wr   = we_i && (waddr_i == ADDR_COUNT);
    assign compare_wr = we_i && (waddr_i == ADDR_COMPARE);
    assign tick       = (presc_q == 4'(COUNT_DIV - 1));

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            ip_hw_q <= '0;
        end else begin
            sync_q[0] <= int_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            ip_hw_q <= ext_ip;
        end
    end

    // NOTE: default first so unused IP lines never infer a latch.
    always_comb begin
        ext_ip = '0;
        ext_ip[NUM_INT-1:0] = sync_q[SYNC_STAGES-1];
    end

    // A Count write restarts the prescaler and overrides the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
        end else begin
            if (count_wr) begin
                count_q <= wdata_i;
                presc_q <= '0;
            end else if (tick) begin
                count_q <= count_q + 32'd1;
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 4'd1;
            end
            if (compare_wr) compare_q <= wdata_i;
        end
    end

    if (TIMER_EN != 0) begin : g_timer
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                timer_q <= 1'b0;
            else if (compare_wr)
                timer_q <= 1'b0;
            else if (count_q == compare_q && compare_q != '0)
                timer_q <= 1'b1;
        end
    end else begin : g_no_timer
        assign timer_q = 1'b0;
    end

    // Exception entry beats ERET, and both drop a same-cycle Status/Cause/EPC write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            epc_q      <= '0;
        end else if (exc_valid_i) begin
            if (!exl_q) begin
                epc_q <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_q  <= exc_bd_i;
            end
            exl_q      <= 1'b1;
            exc_code_q <= execode_i;
        end else if (eret_i) begin
            exl_q <= 1'b0;
        end else if (we_i) begin
            case (waddr_i)
                ADDR_STATUS: begin
                    im_q  <= wdata_i[15:8];
                    exl_q <= wdata_i[1];
                    ie_q  <= wdata_i[0];
                end
                ADDR_CAUSE: ip_sw_q <= wdata_i[9:8];
                ADDR_EPC:   epc_q   <= wdata_i;
                default: ;
            endcase
        end
    end

    assign ip          = {ip_hw_q[7] | timer_q, ip_hw_q[6:2], ip_sw_q};
    assign status_o    = {16'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_o     = {bd_q, 15'd0, ip, 1'b0, exc_code_q, 2'b00};
    assign epc_o       = epc_q;
    assign timer_int_o = timer_q;
    assign int_req_o   = ie_q & ~exl_q & (|(ip & im_q));

    always_comb begin
        data_o = '0;
        case (raddr_i)
            ADDR_COUNT:   data_o = count_q;
            ADDR_COMPARE: data_o = compare_q;
            ADDR_STATUS:  data_o = status_o;
            ADDR_CAUSE:   data_o = cause_o;
            ADDR_EPC:     data_o = epc_q;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: two instances (COUNT_DIV 1 and 4) share stimulus
// and are compared every cycle against a behavioural model, plus literal spot checks.
module tb_cp0_intc;

    localparam int NI = 6;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NI-1:0] int_i = '0;
    logic [4:0]    raddr = '0;
    logic          we = 1'b0;
    logic [4:0]    waddr = '0;
    logic [31:0]   wdata = '0;
    logic          exc_valid = 1'b0;
    logic [4:0]    execode = '0;
    logic [31:0]   exc_pc = '0;
    logic          exc_bd = 1'b0;
    logic          eret = 1'b0;

    logic [31:0] data_q   [2];
    logic        int_req  [2];
    logic        timer_int[2];
    logic [31:0] status_q [2];
    logic [31:0] cause_q  [2];
    logic [31:0] epc_q    [2];

    int total = 0;
    int bad   = 0;

    cp0_intc #(.NUM_INT(NI), .SYNC_STAGES(SS), .TIMER_EN(1), .COUNT_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .int_i(int_i), .raddr_i(raddr), .data_o(data_q[0]),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .exc_valid_i(exc_valid),
        .execode_i(execode), .exc_pc_i(exc_pc), .exc_bd_i(exc_bd), .eret_i(eret),
        .int_req_o(int_req[0]), .timer_int_o(timer_int[0]), .status_o(status_q[0]),
        .cause_o(cause_q[0]), .epc_o(epc_q[0])
    );

    cp0_intc #(.NUM_INT(NI), .SYNC_STAGES(SS), .TIMER_EN(1), .COUNT_DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .int_i(int_i), .raddr_i(raddr), .data_o(data_q[1]),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .exc_valid_i(exc_valid),
        .execode_i(execode), .exc_pc_i(exc_pc), .exc_bd_i(exc_bd), .eret_i(eret),
        .int_req_o(int_req[1]), .timer_int_o(timer_int[1]), .status_o(status_q[1]),
        .cause_o(cause_q[1]), .epc_o(epc_q[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_count [2];
    int unsigned m_since [2];
    logic        m_timer [2];
    logic [31:0] m_compare;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [31:0] m_epc;
    logic [NI-1:0] hist [4];

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = '0;
            m_since[i] = 0;
            m_timer[i] = 1'b0;
        end
        for (int h = 0; h < 4; h++) hist[h] = '0;
        m_compare = '0; m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0;
        m_code = '0; m_ipsw = '0; m_epc = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (we && waddr == 5'd11) m_timer[i] = 1'b0;
            else if (m_count[i] == m_compare && m_compare != 0) m_timer[i] = 1'b1;
            if (we && waddr == 5'd9) begin
                m_count[i] = wdata;
                m_since[i] = 0;
            end else begin
                m_since[i] = m_since[i] + 1;
                if (m_since[i] % div_of(i) == 0) m_count[i] = m_count[i] + 1;
            end
        end
        if (we && waddr == 5'd11) m_compare = wdata;
        for (int h = 3; h > 0; h--) hist[h] = hist[h-1];
        hist[0] = int_i;
        if (exc_valid) begin
            if (!m_exl) begin
                m_epc = exc_bd ? exc_pc - 4 : exc_pc;
                m_bd  = exc_bd;
            end
            m_exl  = 1'b1;
            m_code = execode;
        end else if (eret) begin
            m_exl = 1'b0;
        end else if (we) begin
            if (waddr == 5'd12) begin
                m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0];
            end else if (waddr == 5'd13) begin
                m_ipsw = wdata[9:8];
            end else if (waddr == 5'd14) begin
                m_epc = wdata;
            end
        end
    endtask

    function automatic logic [7:0] exp_ip(input int i);
        logic [7:0]    v;
        logic [NI-1:0] hw;
        v  = '0;
        hw = hist[SS];
        for (int k = 0; k < NI; k++) v[2+k] = hw[k];
        v[7]   = v[7] | m_timer[i];
        v[1:0] = m_ipsw;
        return v;
    endfunction

    function automatic logic [31:0] exp_status();
        return {16'd0, m_im, 6'd0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] exp_cause(input int i);
        return {m_bd, 15'd0, exp_ip(i), 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        case (raddr)
            5'd9:    return m_count[i];
            5'd11:   return m_compare;
            5'd12:   return exp_status();
            5'd13:   return exp_cause(i);
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d.data", i),    data_q[i],    exp_data(i));
                check($sformatf("d%0d.status", i),  status_q[i],  exp_status());
                check($sformatf("d%0d.cause", i),   cause_q[i],   exp_cause(i));
                check($sformatf("d%0d.epc", i),     epc_q[i],     m_epc);
                check($sformatf("d%0d.timer", i),   32'(timer_int[i]), 32'(m_timer[i]));
                check($sformatf("d%0d.int_req", i), 32'(int_req[i]),
                      32'(m_ie & ~m_exl & (|(exp_ip(i) & m_im))));
            end
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic take_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        exc_valid = 1'b1; execode = code; exc_pc = pc; exc_bd = bd;
        @(negedge clk);
        exc_valid = 1'b0; exc_bd = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v0, output logic [31:0] v1);
        raddr = a;
        #1;
        v0 = data_q[0];
        v1 = data_q[1];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r0, r1;

        // Reset with all interrupt lines high: every output is zero.
        rst = 1'b0; int_i = '1; raddr = 5'd13;
        #3;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst d%0d.data", i),  data_q[i],   32'd0);
            check($sformatf("rst d%0d.cause", i), cause_q[i],  32'd0);
            check($sformatf("rst d%0d.irq", i),   32'(int_req[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (SS) @(negedge clk);
        check("ip before sync latency", cause_q[0], 32'h0000_0000);
        @(negedge clk);
        check("ip after sync latency", cause_q[0], 32'h0000_FC00);
        int_i = '0;
        repeat (4) @(negedge clk);

        // Timer with COUNT_DIV=1.
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd0);
        repeat (20) @(negedge clk);
        rd(5'd9, r0, r1);
        check("count reaches 20", r0, 32'd20);
        check("timer not yet", 32'(timer_int[0]), 32'd0);
        @(negedge clk);
        check("timer set", 32'(timer_int[0]), 32'd1);
        repeat (5) @(negedge clk);
        check("timer sticky", 32'(timer_int[0]), 32'd1);
        mtc0(5'd11, 32'd20);
        check("timer cleared by compare write", 32'(timer_int[0]), 32'd0);

        // Interrupt masking.
        mtc0(5'd12, 32'h0000_0401);
        int_i[0] = 1'b1;
        repeat (SS) @(negedge clk);
        check("irq before latency", 32'(int_req[0]), 32'd0);
        @(negedge clk);
        check("irq asserted", 32'(int_req[0]), 32'd1);
        mtc0(5'd12, 32'h0000_0403);
        check("irq masked by exl", 32'(int_req[0]), 32'd0);
        mtc0(5'd12, 32'h0000_0001);
        check("irq masked by im", 32'(int_req[0]), 32'd0);
        int_i = '0;
        repeat (4) @(negedge clk);

        // Exception entry, nested exception, ERET.
        take_exc(5'd12, 32'h0000_0100, 1'b1);
        check("exc epc", epc_q[0], 32'h0000_00FC);
        check("exc cause", cause_q[0], 32'h8000_0030);
        check("exc status", status_q[0], 32'h0000_0003);
        take_exc(5'd4, 32'h0000_0200, 1'b0);
        check("nested epc", epc_q[0], 32'h0000_00FC);
        check("nested cause", cause_q[0], 32'h8000_0010);
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        check("eret status", status_q[0], 32'h0000_0001);

        // Collisions.
        we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1234;
        exc_valid = 1'b1; execode = 5'd8; exc_pc = 32'h0000_0300; exc_bd = 1'b0;
        @(negedge clk);
        we = 1'b0; exc_valid = 1'b0;
        check("exc beats mtc0 epc", epc_q[0], 32'h0000_0300);
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        check("eret clears exl", status_q[0], 32'h0000_0001);
        exc_valid = 1'b1; eret = 1'b1; execode = 5'd10; exc_pc = 32'h0000_0400;
        @(negedge clk);
        exc_valid = 1'b0; eret = 1'b0;
        check("exc beats eret", status_q[0], 32'h0000_0003);
        mtc0(5'd9, 32'd5);
        rd(5'd9, r0, r1);
        check("count write on tick d1", r0, 32'd5);
        check("count write d4", r1, 32'd5);

        // Wrap with COUNT_DIV=4, then asynchronous reset mid-run.
        mtc0(5'd9, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        rd(5'd9, r0, r1);
        check("d4 holds before tick", r1, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(5'd9, r0, r1);
        check("d4 wrapped", r1, 32'd0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        rd(5'd9, r0, r1);
        check("async reset count d4", r1, 32'd0);
        check("async reset count d1", r0, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: waddr = 5'd9;
                1: waddr = 5'd11;
                2: waddr = 5'd12;
                3: waddr = 5'd13;
                4: waddr = 5'd14;
                default: waddr = 5'($urandom_range(0, 31));
            endcase
            wdata     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            exc_valid = ($urandom_range(0, 15) == 0);
            eret      = ($urandom_range(0, 15) == 0);
            execode   = 5'($urandom_range(0, 31));
            exc_pc    = $urandom;
            exc_bd    = 1'($urandom_range(0, 1));
            raddr     = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) int_i = NI'($urandom);
        end
        @(negedge clk);
        we = 1'b0; exc_valid = 1'b0; eret = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
